// File: rtl/frame_byte_sequencer.sv
// frame_byte_sequencer: drains one frame of wide words from a standard-mode
// FIFO and serialises each word MSB byte first onto a valid/ready byte stream,
// counting bytes against the frame length and pulsing frame_done at the end.
// Build option: define SEQ_PREFETCH_EN to add a one-word holding register that
// fetches the next word while the current one is being sent (zero bubble).

module frame_byte_sequencer #(
  parameter int WIDE_W      = 256,
  parameter int FRAME_BYTES = 921600,
  parameter int CNT_W       = 24
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic              abort,
  input  logic              fifo_empty,
  output logic              fifo_rden,
  input  logic [WIDE_W-1:0] fifo_dout,
  output logic [7:0]        byte_data,
  output logic              byte_valid,
  input  logic              byte_ready,
  output logic              busy,
  output logic              frame_done,
  output logic [CNT_W-1:0]  byte_count
);

  // Count value held while the final byte of the frame is on the bus.
  localparam logic [CNT_W-1:0] LAST_COUNT = CNT_W'(FRAME_BYTES - 1);

  typedef enum logic [2:0] {S_IDLE, S_REQ, S_WAIT, S_SEND, S_DONE} state_t;

  state_t            state;
  state_t            state_nxt;
  logic [WIDE_W-1:0] shreg;
  logic [4:0]        lane;
  logic              accept;
  logic              word_end;
  logic              next_avail;
  logic [WIDE_W-1:0] next_word;
  logic              pf_rden;

  // Abort wins over a handshake landing in the same cycle.
  assign accept   = (state == S_SEND) && byte_ready && !abort;
  assign word_end = accept && (lane == 5'd31);

`ifdef SEQ_PREFETCH_EN
  localparam logic [CNT_W-1:0] FRAME_WORDS = CNT_W'(FRAME_BYTES / (WIDE_W / 8));

  logic [WIDE_W-1:0] hold;
  logic              hold_valid;
  logic              pf_pending;
  logic [CNT_W-1:0]  rd_count;

  // A prefetch is never issued on the word-end cycle: if nothing is buffered
  // there the FSM drops to REQ, which issues its own read.
  assign pf_rden    = (state == S_SEND) && !abort && !fifo_empty && !hold_valid &&
                      !pf_pending && !word_end && (rd_count < FRAME_WORDS);
  // A read in flight counts as available: its data is on fifo_dout this cycle.
  assign next_avail = hold_valid || pf_pending;
  assign next_word  = hold_valid ? hold : fifo_dout;

  // Holding register, in-flight prefetch flag and per-frame read counter.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      hold       <= '0;
      hold_valid <= 1'b0;
      pf_pending <= 1'b0;
      rd_count   <= '0;
    end else begin
      pf_pending <= pf_rden;
      if (state == S_IDLE && start) begin
        rd_count <= '0;
      end else if (fifo_rden) begin
        rd_count <= rd_count + CNT_W'(1);
      end
      if (abort && state != S_IDLE) begin
        hold_valid <= 1'b0;
      end else if (pf_pending && !word_end) begin
        hold       <= fifo_dout;
        hold_valid <= 1'b1;
      end else if (word_end) begin
        hold_valid <= 1'b0;
      end
    end
  end
`else
  assign pf_rden    = 1'b0;
  assign next_avail = 1'b0;
  assign next_word  = '0;
`endif

  // State register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples pre-edge values regardless of block evaluation order.
      state <= state_nxt;
    end
  end

  // Next-state logic; abort from any busy state returns to IDLE.
  always_comb begin
    state_nxt = state;
    if (abort && state != S_IDLE) begin
      state_nxt = S_IDLE;
    end else begin
      case (state)
        S_IDLE: if (start) state_nxt = S_REQ;
        S_REQ:  if (!fifo_empty) state_nxt = S_WAIT;
        S_WAIT: state_nxt = S_SEND;
        S_SEND: begin
          if (word_end) begin
            if (byte_count == LAST_COUNT) state_nxt = S_DONE;
            else if (next_avail)          state_nxt = S_SEND;
            else                          state_nxt = S_REQ;
          end
        end
        S_DONE:  state_nxt = S_IDLE;
        default: state_nxt = S_IDLE;
      endcase
    end
  end

  // Output decode from the current state.
  always_comb begin
    // NOTE: every output gets a default before the case so no path leaves one
    // unassigned, which would otherwise infer a latch.
    fifo_rden  = 1'b0;
    byte_valid = 1'b0;
    frame_done = 1'b0;
    case (state)
      S_REQ:   fifo_rden  = !fifo_empty && !abort;
      S_SEND:  byte_valid = 1'b1;
      S_DONE:  frame_done = 1'b1;
      default: ;
    endcase
    if (pf_rden) fifo_rden = 1'b1;
    busy = (state != S_IDLE);
  end

  assign byte_data = shreg[WIDE_W-1 -: 8];

  // Shift register, lane counter and frame byte counter.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      // NOTE: the wide shift register is reset on purpose: byte_data is taken
      // straight from its top byte and must read zero out of reset.
      shreg      <= '0;
      lane       <= '0;
      byte_count <= '0;
    end else begin
      if (state == S_IDLE && start) begin
        byte_count <= '0;
      end else if (accept) begin
        byte_count <= byte_count + CNT_W'(1);
      end
      if (state == S_WAIT && !abort) begin
        shreg <= fifo_dout;
        lane  <= '0;
      end else if (accept) begin
        lane  <= lane + 5'd1;
        shreg <= (lane == 5'd31 && next_avail) ? next_word : (shreg << 8);
      end
    end
  end

endmodule

// File: tb/tb_frame_byte_sequencer.sv
// Self-checking bench for frame_byte_sequencer with a 64-byte frame.
// A FIFO model feeds words; every word pushed also pushes its 32 expected
// bytes (MSB lane first) into a scoreboard that is popped on each handshake.

module tb_frame_byte_sequencer;

  localparam int FB = 64;
  localparam int CW = 24;
`ifdef SEQ_PREFETCH_EN
  localparam int EXP_GAP      = 0;
  localparam int EXP_RD_EARLY = 2;
`else
  localparam int EXP_GAP      = 2;
  localparam int EXP_RD_EARLY = 1;
`endif

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic          fifo_empty = 1'b1;
  logic          fifo_rden;
  logic [255:0]  fifo_dout = '0;
  logic [7:0]    byte_data;
  logic          byte_valid;
  logic          byte_ready = 1'b0;
  logic          busy;
  logic          frame_done;
  logic [CW-1:0] byte_count;

  int n_vec = 0;
  int n_err = 0;

  logic [255:0] fq[$];
  logic [7:0]   exp_q[$];
  logic [255:0] pop_w;
  logic [7:0]   mon_e;

  int done_cnt  = 0;
  int frame_rd  = 0;
  int frame_acc = 0;
  int gap_cnt   = 0;
  int rden_viol = 0;
  bit seen      = 1'b0;
  bit stall_prev = 1'b0;
  logic [7:0] stall_data = '0;
  int d0;

  always #5 clock = ~clock;

  frame_byte_sequencer #(.WIDE_W(256), .FRAME_BYTES(FB), .CNT_W(CW)) dut (
    .clock      (clock),
    .reset      (reset),
    .start      (start),
    .abort      (abort),
    .fifo_empty (fifo_empty),
    .fifo_rden  (fifo_rden),
    .fifo_dout  (fifo_dout),
    .byte_data  (byte_data),
    .byte_valid (byte_valid),
    .byte_ready (byte_ready),
    .busy       (busy),
    .frame_done (frame_done),
    .byte_count (byte_count)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Word with byte k (bits 8k+7:8k) = base+k; sent MSB lane first.
  task automatic push_word(input logic [7:0] base);
    logic [255:0] w;
    for (int k = 0; k < 32; k++) w[8*k +: 8] = base + 8'(k);
    fq.push_back(w);
    for (int k = 31; k >= 0; k--) exp_q.push_back(base + 8'(k));
    fifo_empty = 1'b0;
  endtask

  // Standard-mode FIFO: data appears the cycle after the read strobe.
  always @(posedge clock) begin
    if (fifo_rden && fq.size() > 0) begin
      pop_w = fq.pop_front();
      fifo_dout  <= pop_w;
      fifo_empty <= (fq.size() == 0);
    end
  end

  // Monitor: sampled mid-cycle, ahead of the edge that completes a handshake.
  always @(negedge clock) begin
    if (!reset) begin
      if (stall_prev) begin
        check("hold_data", byte_data, stall_data);
        check("hold_valid", byte_valid, 1);
      end
      stall_prev = byte_valid && !byte_ready && !abort;
      stall_data = byte_data;
      if (start && !busy) begin
        frame_rd  = 0;
        frame_acc = 0;
        gap_cnt   = 0;
        seen      = 1'b0;
      end
      if (fifo_rden) begin
        frame_rd++;
        if (fifo_empty) rden_viol++;
      end
      if (frame_done) done_cnt++;
      if (busy && !byte_valid && !frame_done && seen) gap_cnt++;
      if (byte_valid && byte_ready && !abort) begin
        if (exp_q.size() > 0) mon_e = exp_q.pop_front();
        else                  mon_e = 'x;
        check("byte", byte_data, mon_e);
        frame_acc++;
        seen = 1'b1;
      end
    end
  end

  task automatic wait_done(input string tag, input int budget, input bit toggle);
    int  base = done_cnt;
    bit  got  = 1'b0;
    for (int i = 0; i < budget && !got; i++) begin
      @(posedge clock);
      #1;
      if (toggle) byte_ready = ~byte_ready;
      if (done_cnt != base) got = 1'b1;
    end
    check({tag, "_done_wait"}, got, 1);
    byte_ready = 1'b1;
    @(negedge clock);
  endtask

  task automatic wait_acc(input string tag, input int n, input int budget);
    bit got = 1'b0;
    for (int i = 0; i < budget && !got; i++) begin
      @(posedge clock);
      if (frame_acc >= n) got = 1'b1;
    end
    check({tag, "_acc_wait"}, got, 1);
  endtask

  task automatic start_frame();
    @(posedge clock);
    #1 start = 1'b1;
    @(posedge clock);
    #1 start = 1'b0;
  endtask

  initial begin
    // Reset with the FIFO preloaded and no start.
    push_word(8'h00);
    push_word(8'h20);
    repeat (3) @(posedge clock);
    #1 reset = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      check("rst_idle", {fifo_rden, byte_valid, busy, frame_done, byte_data, byte_count}, 0);
    end

    // Full frame with continuous ready.
    d0 = done_cnt;
    byte_ready = 1'b1;
    start_frame();
    wait_done("f1", 400, 1'b0);
    check("f1_count", byte_count, FB);
    check("f1_busy", busy, 0);
    check("f1_reads", frame_rd, 2);
    check("f1_done", done_cnt - d0, 1);
    check("f1_gap", gap_cnt, EXP_GAP);
    check("f1_sb", exp_q.size(), 0);

    // Backpressure: ready toggles every cycle.
    @(posedge clock);
    #1;
    push_word(8'h40);
    push_word(8'h60);
    d0 = done_cnt;
    start_frame();
    wait_done("bp", 800, 1'b1);
    check("bp_count", byte_count, FB);
    check("bp_reads", frame_rd, 2);
    check("bp_done", done_cnt - d0, 1);
    check("bp_sb", exp_q.size(), 0);

    // Starvation: FIFO empty for 50 cycles after the first word.
    @(posedge clock);
    #1 push_word(8'h80);
    d0 = done_cnt;
    start_frame();
    wait_acc("st", 32, 200);
    for (int i = 0; i < 50; i++) begin
      @(negedge clock);
      check("st_stall", {byte_valid, fifo_rden, busy}, 3'b001);
    end
    check("st_reads", frame_rd, 1);
    @(posedge clock);
    #1 push_word(8'hA0);
    wait_done("st", 400, 1'b0);
    check("st_count", byte_count, FB);
    check("st_reads_end", frame_rd, 2);
    check("st_done", done_cnt - d0, 1);
    check("st_sb", exp_q.size(), 0);

    // Abort after ten bytes of the first word.
    @(posedge clock);
    #1 push_word(8'hC0);
    d0 = done_cnt;
    start_frame();
    wait_acc("ab", 10, 200);
    #1 abort = 1'b1;
    @(posedge clock);
    #1 abort = 1'b0;
    @(negedge clock);
    check("ab_valid", byte_valid, 0);
    check("ab_count", byte_count, 10);
    check("ab_busy", busy, 0);
    check("ab_reads", frame_rd, 1);
    check("ab_sb", exp_q.size(), 22);
    repeat (22) void'(exp_q.pop_front());
    repeat (5) @(negedge clock);
    check("ab_no_done", done_cnt - d0, 0);
    check("ab_count_hold", byte_count, 10);
    @(posedge clock);
    #1;
    push_word(8'hE0);
    push_word(8'h01);
    start_frame();
    wait_done("ab2", 400, 1'b0);
    check("ab2_count", byte_count, FB);
    check("ab2_reads", frame_rd, 2);
    check("ab2_sb", exp_q.size(), 0);

    // Start pulsed while busy is ignored.
    @(posedge clock);
    #1;
    push_word(8'h11);
    push_word(8'h31);
    d0 = done_cnt;
    start_frame();
    wait_acc("sb", 5, 200);
    #1;
    byte_ready = 1'b0;
    start = 1'b1;
    @(posedge clock);
    #1 start = 1'b0;
    @(negedge clock);
    check("sb_count", byte_count, 5);
    check("sb_busy", busy, 1);
    check("sb_reads", frame_rd, EXP_RD_EARLY);
    @(posedge clock);
    #1 byte_ready = 1'b1;
    wait_done("sb", 400, 1'b0);
    check("sb_count_end", byte_count, FB);
    check("sb_reads_end", frame_rd, 2);
    check("sb_done", done_cnt - d0, 1);
    check("sb_sb", exp_q.size(), 0);

    check("rden_empty", rden_viol, 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/frame_byte_sequencer.md
Name: frame_byte_sequencer

Overview:
Controller that drains a frame of 256-bit words from an upstream standard-mode FIFO and presents it byte by byte to a valid/ready byte consumer, such as the UART transmit path for picture data. It sequences the FIFO read strobe and holds one word in a shift register. It serialises each word MSB-byte first, counts bytes against the frame length, and signals frame completion. It sits between the wide picture-buffer FIFO and the UART/byte stream.

Parameters:
WIDE_W, 256, upstream word width; fixed at 256, giving 32 lanes per word
FRAME_BYTES, 921600, bytes per frame; must be a nonzero multiple of 32
CNT_W, 24, width of byte counter; must satisfy 2^CNT_W > FRAME_BYTES

Ports:
clock  in  1  system clock, all logic on rising edge
reset  in  1  asynchronous, active-high reset
start  in  1  single-cycle pulse that begins a frame; honoured only in IDLE
abort  in  1  synchronous abort; returns to IDLE next cycle
fifo_empty  in  1  upstream FIFO empty flag
fifo_rden  out  1  upstream read strobe; data valid the cycle after
fifo_dout  in  256  upstream read data
byte_data  out  8  current byte
byte_valid  out  1  byte_data valid
byte_ready  in  1  consumer accepts byte when valid&&ready
busy  out  1  high from the cycle after an accepted start until DONE exits
frame_done  out  1  one-cycle pulse after the last byte of a frame is accepted
byte_count  out  CNT_W  bytes accepted in the current/last frame

Behaviour:
- Reset, asynchronous: state=IDLE; fifo_rden, byte_valid, busy and frame_done = 0; byte_data=0; byte_count=0; shift reg and lane counter = 0.
- States: IDLE, REQ, WAIT, SEND, DONE.
- IDLE: start=1 -> REQ; byte_count cleared to 0; busy=1 from the next cycle. start in any other state is ignored.
- REQ: fifo_rden=1 only in a cycle where fifo_empty=0, then -> WAIT. Stalls indefinitely while the FIFO is empty. fifo_rden is never asserted while fifo_empty=1.
- WAIT: capture fifo_dout into the shift reg, lane=0, -> SEND.
- SEND: byte_valid=1, byte_data=shreg[255:248]. On valid&&ready: shift left 8, lane+1, byte_count+1.
  - byte_data is held stable while ready=0; byte_valid never drops without a handshake, except on abort or reset.
- On acceptance of lane 31:
  - if byte_count+1 == FRAME_BYTES -> DONE;
  - else -> REQ.
  - Baseline bubble between words is 2 cycles (REQ, WAIT) when the FIFO is non-empty.
- DONE: frame_done=1 for exactly one cycle, busy=0 next cycle, -> IDLE. byte_count holds its final value until the next start.
- abort=1 in any non-IDLE state -> IDLE next cycle.
  - byte_valid=0, fifo_rden=0, no frame_done.
  - byte_count holds.
  - A read already issued in REQ is discarded.
  - abort has priority over handshake completion in the same cycle.
- Reset mid-frame: immediate return to reset values; no pending read is resumed.
- byte_ready is ignored outside SEND.
- Exactly FRAME_BYTES/32 FIFO reads are performed per completed frame.

Optional Feature:
Macro SEQ_PREFETCH_EN.
- Defined: adds a 256-bit holding register plus a valid flag.
  - During SEND, if the holding register is empty, more words remain for the frame and fifo_empty=0, issue one fifo_rden and load the holding register the next cycle.
  - On lane-31 acceptance with the holding register valid: load the shift reg from the holding register and stay in SEND. The next byte is presented the following cycle, giving zero bubble.
  - If the holding register is empty at that point, fall back to REQ.
  - Read count per frame is unchanged. abort also clears the holding flag.
- Undefined: no holding register; 2-cycle inter-word bubble as in the base behaviour.

Test Plan:
- Reset → outputs: reset with FIFO preloaded, no start -> fifo_rden=0, byte_valid=0, busy=0, byte_count=0 for 20 cycles.
- Full frame, continuous ready: FRAME_BYTES=64, two words 0x1F1E..00 and 0x3F3E..20 preloaded, start, ready=1 -> bytes 0x1F..0x00 then 0x3F..0x20; exactly 2 rden pulses; frame_done once; byte_count=64. Inter-word gap is 2 cycles, or 0 with SEQ_PREFETCH_EN.
- Backpressure: ready toggled 1/0 each cycle -> byte_data stable while ready=0; no byte lost or duplicated; byte_count=64 at done.
- Starvation: FIFO empty for 50 cycles after the first word -> state held in REQ with rden=0; resumes when a word is written; frame completes correctly.
- Abort mid-word: abort at byte 10 -> byte_valid=0 next cycle; no frame_done; byte_count=10. A new start then reads the next FIFO word from lane 0.
- Start while busy: pulse start during SEND -> ignored; byte_count and read count unchanged.
